// File: rtl/pixel_layer_mux.sv
// Registered N-layer pixel selector/compositor with frame-synchronous, double-buffered configuration.
// Sync and valid share the single output stage with the pixel so they always stay aligned.
module pixel_layer_mux #(
    parameter  int PIXEL_W    = 6,
    parameter  int NUM_LAYERS = 4,
    localparam int SEL_W      = $clog2(NUM_LAYERS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_LAYERS*PIXEL_W-1:0] pix_in,
    input  logic                          pix_valid,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          frame_start,
    input  logic                          cfg_wr,
    input  logic [SEL_W-1:0]              sel_req,
    input  logic                          mode_req,
    input  logic [PIXEL_W-1:0]            key_req,
    output logic [PIXEL_W-1:0]            pix_out,
    output logic                          pix_valid_out,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic                          cfg_pending,
    output logic [SEL_W-1:0]              active_sel
);

    typedef enum logic {
        MODE_DIRECT   = 1'b0,
        MODE_PRIORITY = 1'b1
    } mode_t;

    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_LAYERS - 1);

    logic [PIXEL_W-1:0] layer [NUM_LAYERS];
    logic [SEL_W-1:0]   sel_clamped;
    logic [SEL_W-1:0]   shadow_sel;
    mode_t              shadow_mode;
    logic [PIXEL_W-1:0] shadow_key;
    mode_t              active_mode;
    logic [PIXEL_W-1:0] active_key;
    logic [PIXEL_W-1:0] direct_pix;
    logic [PIXEL_W-1:0] prio_pix;
    logic [PIXEL_W-1:0] selected;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_unpack
        assign layer[g] = pix_in[g*PIXEL_W +: PIXEL_W];
    end

    // Out-of-range selects (only possible for non-power-of-2 layer counts) stick to the top layer.
    assign sel_clamped = (sel_req > MAX_SEL) ? MAX_SEL : sel_req;

    // A write in the frame_start cycle bypasses the shadow so the request takes effect immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_sel  <= '0;
            shadow_mode <= MODE_DIRECT;
            shadow_key  <= '0;
            active_sel  <= '0;
            active_mode <= MODE_DIRECT;
            active_key  <= '0;
            cfg_pending <= 1'b0;
        end else if (frame_start && cfg_wr) begin
            shadow_sel  <= sel_clamped;
            shadow_mode <= mode_t'(mode_req);
            shadow_key  <= key_req;
            active_sel  <= sel_clamped;
            active_mode <= mode_t'(mode_req);
            active_key  <= key_req;
            cfg_pending <= 1'b0;
        end else if (frame_start) begin
            if (cfg_pending) begin
                active_sel  <= shadow_sel;
                active_mode <= shadow_mode;
                active_key  <= shadow_key;
                cfg_pending <= 1'b0;
            end
        end else if (cfg_wr) begin
            shadow_sel  <= sel_clamped;
            shadow_mode <= mode_t'(mode_req);
            shadow_key  <= key_req;
            cfg_pending <= 1'b1;
        end
    end

    // Ascending scan: the last non-key layer at or below active_sel wins; layer 0 is the fallback.
    always_comb begin
        direct_pix = layer[0];
        prio_pix   = layer[0];
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (SEL_W'(i) == active_sel) begin
                direct_pix = layer[i];
            end
            if ((SEL_W'(i) <= active_sel) && (layer[i] != active_key)) begin
                prio_pix = layer[i];
            end
        end
        selected = (active_mode == MODE_PRIORITY) ? prio_pix : direct_pix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out       <= '0;
            pix_valid_out <= 1'b0;
            hsync_out     <= 1'b0;
            vsync_out     <= 1'b0;
        end else begin
            pix_out       <= pix_valid ? selected : '0;
            pix_valid_out <= pix_valid;
            hsync_out     <= hsync_in;
            vsync_out     <= vsync_in;
        end
    end

endmodule

// File: doc/pixel_layer_mux.md
Name: pixel_layer_mux

Overview:
- Registered, parametrised N-layer pixel selector/compositor for the VGA pixel path; sits between the layer generators (background, sprite, text, cursor) and the VGA output stage.
- Two modes: direct select, and priority compositing with a transparency key colour.
- Configuration is double-buffered and committed only on a frame_start pulse, so a mid-frame change never tears the image.
- Sync and valid travel through the same pipeline stage as the pixel, so they stay aligned.

Parameters:
PIXEL_W, 6, bits per pixel (RRGGBB)
NUM_LAYERS, 4, number of input layers (2..16)
SEL_W, $clog2(NUM_LAYERS), derived localparam; not overridable

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pix_in  in  NUM_LAYERS*PIXEL_W  flattened layer pixels; layer i at [i*PIXEL_W +: PIXEL_W]
pix_valid  in  1  active-video qualifier for pix_in
hsync_in  in  1  horizontal sync, passed through
vsync_in  in  1  vertical sync, passed through
frame_start  in  1  single-cycle pulse at frame boundary; commits pending config
cfg_wr  in  1  captures sel_req/mode_req/key_req into shadow registers
sel_req  in  SEL_W  requested layer select (direct) or top layer (priority)
mode_req  in  1  0 = DIRECT, 1 = PRIORITY
key_req  in  PIXEL_W  transparency key colour
pix_out  out  PIXEL_W  registered output pixel
pix_valid_out  out  1  pix_valid delayed 1 cycle
hsync_out  out  1  hsync_in delayed 1 cycle
vsync_out  out  1  vsync_in delayed 1 cycle
cfg_pending  out  1  shadow config written but not yet committed
active_sel  out  SEL_W  currently committed select

Behaviour:
- Reset (async assert, sync deassert at clk): pix_out = 0, pix_valid_out = 0, hsync_out = 0, vsync_out = 0, cfg_pending = 0, active_sel = 0, active mode = DIRECT, active key = 0, all shadow registers = 0.
- Config shadow:
  - cfg_wr = 1 (no frame_start): shadow <= {sel_req, mode_req, key_req}; cfg_pending <= 1.
  - Repeated writes before commit: last write wins.
- Commit on frame_start = 1:
  - cfg_wr = 0 and cfg_pending = 1: active <= shadow; cfg_pending <= 0.
  - cfg_wr = 0 and cfg_pending = 0: no change.
  - cfg_wr = 1 in the same cycle: bypass. active <= request inputs; shadow <= request inputs; cfg_pending <= 0.
- Commit timing: the pixel sampled in the frame_start cycle uses the OLD config; the new config applies from the next cycle.
- Select clamp: sel_req >= NUM_LAYERS (non-power-of-2 NUM_LAYERS only) is clamped to NUM_LAYERS-1 at capture time.
- DIRECT mode: selected = layer[active_sel].
- PRIORITY mode:
  - selected = highest-index layer i with i <= active_sel and layer[i] != active key.
  - If every layer 0..active_sel equals the key, selected = layer0 (key colour passes through).
  - Layers above active_sel are ignored.
- Output stage, latency exactly 1 cycle:
  - pix_out <= pix_valid ? selected : 0 (forced blank outside active video).
  - pix_valid_out, hsync_out and vsync_out are registered in the same stage.
  - All four outputs are aligned every cycle; there is no stall or backpressure.
- Reset mid-frame: all outputs return to reset values immediately. A pending config is discarded and active config returns to DIRECT, sel 0.
- Selection logic is combinational, parameterised over NUM_LAYERS; no width truncation of pixel data anywhere.

Test Plan:
- Reset/direct path (defaults): pix_in layers = {6'h08, 6'h04, 6'h02, 6'h01} (L3..L0), pix_valid = 1, no config written -> pix_out = 6'h01 one cycle later; all outputs 0 during rst_n = 0.
- Deferred commit: cfg_wr with sel_req = 2, mode_req = 0 -> cfg_pending = 1 and pix_out stays 6'h01. Pulse frame_start -> pix_out = 6'h01 for the frame_start-cycle pixel, then 6'h04; cfg_pending = 0; active_sel = 2.
- Priority/transparency: key = 6'h00, sel = 3, mode = 1, committed. Layers L3 = 00, L2 = 3F, L1 = 15, L0 = 2A -> pix_out = 3F. Set L2 = 00 -> 15. All layers = 00 -> 00. sel = 1 with L2 = 3F -> 15 (L2 ignored).
- Blank and sync alignment: pix_valid = 0 with non-zero layers -> pix_out = 0. Toggle hsync_in/vsync_in on cycle n -> hsync_out/vsync_out toggle on cycle n+1, aligned with pix_valid_out.
- Simultaneous events and last-write-wins:
  - cfg_wr sel = 1, then cfg_wr sel = 3, then frame_start -> active_sel = 3.
  - cfg_wr sel = 0 in the same cycle as frame_start -> active_sel = 0, cfg_pending = 0.
- Clamp and reset mid-operation: with NUM_LAYERS = 3, sel_req = 3 -> active_sel = 2 after commit. Assert rst_n mid-frame while cfg_pending = 1 -> cfg_pending = 0, active_sel = 0, pix_out = 0 immediately.
